// File: rtl/vec_cmd_sequencer.sv
// Vector command sequencer: owns vl and turns one CFU command into N datapath beats plus a response.
// Latency: response 1 cycle after accept (vsetvli, illegal, vl=0), N+1 for beat ops, N+2 with accumulator drain.
// Backpressure: cmd_ready only in IDLE; the response is held stable in RESP until rsp_ready.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cmd_*                        CFU command channel (valid/ready, function_id, two 32-bit operands)
//   rsp_*                        CFU response channel (valid/ready, 32-bit payload)
//   acc_in                       datapath accumulator, captured in DRAIN
//   reg_*_sel, reg_load          vector register file selects and write enable
//   beat_idx, alu_*, bus_sel     per-beat datapath controls
//   acc_clear                    accumulator clear on the first beat of vacc/vbacc
//   vl                           current vector length in elements
module vec_cmd_sequencer #(
    parameter int VREG_AW = 5,
    parameter int LANES   = 4,
    parameter int MAX_VL  = 64,
    localparam int BEAT_W = $clog2(MAX_VL / LANES) + 1,
    localparam int VL_W   = BEAT_W + $clog2(LANES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [9:0]         cmd_payload_function_id,
    input  logic [31:0]        cmd_payload_inputs_0,
    input  logic [31:0]        cmd_payload_inputs_1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_payload_outputs_0,
    input  logic [31:0]        acc_in,
    output logic [VREG_AW-1:0] reg_op0_sel,
    output logic [VREG_AW-1:0] reg_op1_sel,
    output logic [VREG_AW-1:0] reg_wb_sel,
    output logic               reg_load,
    output logic [BEAT_W-1:0]  beat_idx,
    output logic [7:0]         alu_imm,
    output logic               alu_op1_sel,
    output logic [1:0]         bus_sel,
    output logic               acc_clear,
    output logic [VL_W-1:0]    vl
);

    localparam int LANE_SH   = $clog2(LANES);
    localparam int BEATS_MAX = MAX_VL / LANES;

    localparam logic [2:0] OP_VSETVLI = 3'd0;
    localparam logic [2:0] OP_VLOAD   = 3'd1;
    localparam logic [2:0] OP_VADD_VI = 3'd2;
    localparam logic [2:0] OP_VACC    = 3'd3;
    localparam logic [2:0] OP_VMUL    = 3'd4;
    localparam logic [2:0] OP_VBACC   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DRAIN,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    // Command fields captured on accept; later operand changes are ignored.
    logic [2:0]         op_q;
    logic [VREG_AW-1:0] vreg_q;
    logic [VREG_AW-1:0] src0_q;
    logic [VREG_AW-1:0] src1_q;
    logic [7:0]         imm_q;
    logic [BEAT_W-1:0]  ld_idx_q;
    logic [BEAT_W-1:0]  nbeats_q;
    logic [BEAT_W-1:0]  beat_q;

    logic              accept;
    logic [2:0]        cmd_op;
    logic              cmd_is_vec;
    logic [VL_W-1:0]   vl_set;
    logic [VL_W:0]     vl_round;
    logic [BEAT_W-1:0] vl_beats;
    logic [BEAT_W-1:0] cmd_nbeats;
    logic [BEAT_W-1:0] cmd_ld_idx;
    logic              last_beat;
    logic              acc_op_q;
    logic              unused_bits;

    assign accept     = cmd_valid && cmd_ready;
    assign cmd_op     = cmd_payload_function_id[2:0];
    assign cmd_is_vec = (cmd_op >= OP_VADD_VI) && (cmd_op <= OP_VBACC);

    // Beat count uses the vl in force at accept, so a command never sees a later vsetvli.
    assign vl_round   = {1'b0, vl} + (VL_W + 1)'(LANES - 1);
    assign vl_beats   = BEAT_W'(vl_round >> LANE_SH);
    assign cmd_nbeats = (cmd_op == OP_VLOAD) ? BEAT_W'(1) : vl_beats;
    assign cmd_ld_idx = BEAT_W'(cmd_payload_inputs_1 % 32'(BEATS_MAX));

    assign last_beat  = (beat_q == (nbeats_q - BEAT_W'(1)));
    assign acc_op_q   = (op_q == OP_VACC) || (op_q == OP_VBACC);

    // Upper function_id bits are reserved.
    assign unused_bits = ^cmd_payload_function_id;

    always_comb begin
        if (cmd_payload_inputs_0 > 32'(MAX_VL)) begin
            vl_set = VL_W'(MAX_VL);
        end else begin
            vl_set = cmd_payload_inputs_0[VL_W-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_VLOAD) begin
                        state_d = ST_EXEC;
                    end else if (cmd_is_vec && (vl_beats != '0)) begin
                        state_d = ST_EXEC;
                    end else begin
                        // vsetvli, illegal opcodes and zero-length ops answer straight away
                        state_d = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (last_beat) begin
                    state_d = acc_op_q ? ST_DRAIN : ST_RESP;
                end
            end
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture, beat counter, vl and response payload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q                  <= '0;
            vreg_q                <= '0;
            src0_q                <= '0;
            src1_q                <= '0;
            imm_q                 <= '0;
            ld_idx_q              <= '0;
            nbeats_q              <= '0;
            beat_q                <= '0;
            vl                    <= '0;
            rsp_payload_outputs_0 <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= cmd_op;
                        vreg_q   <= cmd_payload_function_id[3 +: VREG_AW];
                        src0_q   <= cmd_payload_inputs_0[VREG_AW-1:0];
                        src1_q   <= cmd_payload_inputs_1[VREG_AW-1:0];
                        imm_q    <= cmd_payload_inputs_1[7:0];
                        ld_idx_q <= cmd_ld_idx;
                        nbeats_q <= cmd_nbeats;
                        beat_q   <= '0;
                        if (cmd_op == OP_VSETVLI) begin
                            vl                    <= vl_set;
                            rsp_payload_outputs_0 <= 32'(vl_set);
                        end else if (cmd_op > OP_VBACC) begin
                            rsp_payload_outputs_0 <= '1;
                        end else if (cmd_is_vec && (vl_beats == '0)) begin
                            rsp_payload_outputs_0 <= '0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (last_beat) begin
                        // accumulating ops take their result from acc_in in DRAIN instead
                        if (!acc_op_q) begin
                            rsp_payload_outputs_0 <= 32'(nbeats_q);
                        end
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                ST_DRAIN: rsp_payload_outputs_0 <= acc_in;
                default: ;
            endcase
        end
    end

    // Output decode: driven only from registered state, so every control is stable for the
    // whole beat and returns to zero as soon as reset asserts.
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE);
        rsp_valid   = (state_q == ST_RESP);
        reg_op0_sel = '0;
        reg_op1_sel = '0;
        reg_wb_sel  = '0;
        reg_load    = 1'b0;
        beat_idx    = '0;
        alu_imm     = '0;
        alu_op1_sel = 1'b0;
        bus_sel     = 2'b00;
        acc_clear   = 1'b0;
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_VLOAD: begin
                    reg_wb_sel = vreg_q;
                    reg_load   = 1'b1;
                    beat_idx   = ld_idx_q;
                    bus_sel    = 2'b00;
                end
                OP_VADD_VI: begin
                    reg_op0_sel = src0_q;
                    alu_imm     = imm_q;
                    alu_op1_sel = 1'b1;
                    bus_sel     = 2'b01;
                    reg_wb_sel  = vreg_q;
                    reg_load    = 1'b1;
                    beat_idx    = beat_q;
                end
                OP_VACC: begin
                    reg_op0_sel = src0_q;
                    beat_idx    = beat_q;
                    acc_clear   = (beat_q == '0);
                end
                OP_VMUL: begin
                    reg_op0_sel = src0_q;
                    reg_op1_sel = src1_q;
                    bus_sel     = 2'b10;
                    reg_wb_sel  = vreg_q;
                    reg_load    = 1'b1;
                    beat_idx    = beat_q;
                end
                OP_VBACC: begin
                    reg_op0_sel = vreg_q;
                    bus_sel     = 2'b11;
                    beat_idx    = beat_q;
                    acc_clear   = (beat_q == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
